// File: rtl/bp_dout_writer_pkg.sv
// Shared LSTM backprop definitions: dout writer FSM encoding and default geometry.
package bp_dout_writer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC   = 3'd1,
    WRITE = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_NUM_CELL   = 8;
  localparam int DEF_NUM_TERM   = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_WR_GAP     = 2;

  // Counter width that stays at least one bit wide for counts of 0 or 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_sat_add.sv
// Signed adder for the dout accumulator; saturates when BP_DOUT_SAT_EN is defined,
// otherwise wraps in two's complement.
module bp_sat_add #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum
);

  logic signed [WIDTH-1:0] raw;

  assign raw = a + b;

`ifdef BP_DOUT_SAT_EN
  logic ovf;

  // Overflow only when both operands share a sign that the raw result lost.
  assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    sum = raw;
    if (ovf) begin
      sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/bp_dout_writer.sv
// Sums NUM_TERM gate contributions per cell and writes NUM_CELL cells to dout memory.
// Define BP_DOUT_SAT_EN for a saturating accumulate (default build wraps).
module bp_dout_writer
  import bp_dout_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_CELL   = DEF_NUM_CELL,
  parameter int NUM_TERM   = DEF_NUM_TERM,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WR_GAP     = DEF_WR_GAP
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_ready,
  output logic                         o_wr_en,
  output logic        [ADDR_WIDTH-1:0] o_wr_addr,
  output logic signed [DATA_WIDTH-1:0] o_wr_data,
  output logic                         o_done
);

  localparam int TERM_W = cnt_width(NUM_TERM);
  localparam int GAP_W  = cnt_width(WR_GAP);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [TERM_W-1:0]       term;
  logic [GAP_W-1:0]        gap_cnt;
  logic signed [DATA_WIDTH-1:0] acc;
  logic signed [DATA_WIDTH-1:0] sum;
  logic                    last_term;
  logic                    last_cell;
  logic                    last_gap;

  bp_sat_add #(
    .WIDTH(DATA_WIDTH)
  ) u_add (
    .a  (acc),
    .b  (i_data),
    .sum(sum)
  );

  assign last_term = (term == TERM_W'(NUM_TERM - 1));
  assign last_cell = (addr == ADDR_WIDTH'(NUM_CELL - 1));
  assign last_gap  = (gap_cnt == GAP_W'(WR_GAP - 1));

  // Strobes decode the registered state but drop instantly when en is low,
  // so a pending WRITE or DONE is simply issued later.
  assign o_ready   = en && (state == ACC);
  assign o_wr_en   = en && (state == WRITE);
  assign o_done    = en && (state == DONE);
  assign o_wr_addr = addr;
  assign o_wr_data = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= '0;
      term    <= '0;
      gap_cnt <= '0;
      acc     <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            addr  <= '0;
            term  <= '0;
            acc   <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          if (i_valid) begin
            acc <= (term == '0) ? i_data : sum;
            if (last_term) begin
              term  <= '0;
              state <= WRITE;
            end else begin
              term <= term + 1'b1;
            end
          end
        end
        WRITE: begin
          if (WR_GAP == 0) begin
            if (last_cell) begin
              state <= DONE;
            end else begin
              addr  <= addr + 1'b1;
              state <= ACC;
            end
          end else begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (last_gap) begin
            gap_cnt <= '0;
            if (last_cell) begin
              state <= DONE;
            end else begin
              addr  <= addr + 1'b1;
              state <= ACC;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DONE: begin
          addr  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bp_dout_writer.md
BP_DOUT_WRITER -- requirements
Module: bp_dout_writer

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set the width of the dout memory address.
REQ-002 Parameter NUM_CELL, default 8, SHALL set the number of cells written per pass.
REQ-003 Parameter NUM_TERM, default 4, SHALL set the number of gate contributions summed per cell; legal range is 1 and above.
REQ-004 Parameter DATA_WIDTH, default 16, SHALL set the signed data width.
REQ-005 Parameter WR_GAP, default 2, SHALL set the idle cycles after each write.
REQ-006 Port clk, input, 1 bit: clock, rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 Port en, input, 1: global enable; low freezes all state.
REQ-009 Port start, input, 1: single-cycle pulse that begins a pass.
REQ-010 Port i_valid, input, 1: input beat valid.
REQ-011 Port i_data, input, DATA_WIDTH: signed contribution.
REQ-012 Port o_ready, output, 1: beat accepted when i_valid && o_ready at clk rise.
REQ-013 Port o_wr_en, output, 1: dout memory write strobe.
REQ-014 Port o_wr_addr, output, ADDR_WIDTH: write address.
REQ-015 Port o_wr_data, output, DATA_WIDTH: summed value.
REQ-016 Port o_done, output, 1: one-cycle pass-complete pulse.

Function
REQ-017 The FSM SHALL have states IDLE, ACC, WRITE, GAP and DONE, with the state held in a register.
REQ-018 In IDLE, start=1 with en=1 SHALL load addr=0, term=0 and acc=0, and SHALL move the FSM to ACC; start SHALL be ignored in every other state.
REQ-019 o_ready SHALL be 1 only when state==ACC and en=1.
REQ-020 On an accepted beat, the first beat of a cell SHALL load acc=i_data and each later beat SHALL set acc=acc+i_data, both at DATA_WIDTH per REQ-032/033.
REQ-021 On an accepted beat, term SHALL increment; the beat with term==NUM_TERM-1 SHALL clear term and move the FSM to WRITE.
REQ-022 In WRITE, o_wr_en=1, o_wr_addr=addr and o_wr_data=acc SHALL be asserted for exactly one cycle, and the FSM SHALL then move to GAP.
REQ-023 The first o_wr_en SHALL occur in the cycle after the last beat is accepted, giving a latency of 1 cycle.
REQ-024 GAP SHALL last WR_GAP cycles with o_ready=0. On exit, addr==NUM_CELL-1 SHALL move the FSM to DONE; otherwise addr SHALL increment and the FSM SHALL move to ACC.
REQ-025 With WR_GAP=0, the GAP state SHALL be skipped.
REQ-026 DONE SHALL assert o_done for one cycle, reset addr to 0 and move the FSM to IDLE; a start in the same cycle SHALL be ignored.
REQ-027 With en=0, state, counters and acc SHALL hold; o_ready, o_wr_en and o_done SHALL be 0; a pending WRITE or DONE SHALL be issued once en returns to 1.
REQ-028 i_valid outside ACC SHALL have no effect, and no data SHALL be dropped or duplicated.
REQ-029 With NUM_TERM=1, every accepted beat SHALL produce a write.
REQ-030 Writes SHALL use addresses 0..NUM_CELL-1, strictly ascending, with no wrap within a pass.

Reset
REQ-031 While rst is high: state=IDLE, addr=0, term=0, acc=0, gap counter=0, and o_ready, o_wr_en, o_wr_data and o_done=0; o_wr_addr=0. Reset mid-pass SHALL abandon the pass with no further write.

Configuration
REQ-032 With BP_DOUT_SAT_EN defined, the accumulate SHALL saturate to the signed max/min of DATA_WIDTH.
REQ-033 Without BP_DOUT_SAT_EN, the accumulate SHALL wrap modulo 2^DATA_WIDTH (two's complement).

Structure
REQ-034 The FSM state encodings and the default NUM_CELL, NUM_TERM, DATA_WIDTH and WR_GAP values SHALL reside in the shared LSTM backprop package/header.
REQ-035 The adder SHALL be a sub-module bp_sat_add whose saturation behaviour is selected by BP_DOUT_SAT_EN.

Verification
REQ-036 Reset, start, then 32 beats of value 1 with i_valid held high -> 8 writes of data 4 at addr 0..7, each followed by 2 o_ready=0 cycles, then a single o_done pulse.
REQ-037 Beats 0x7000 and 0x2000 for one cell -> data 0x7FFF with BP_DOUT_SAT_EN defined, 0x9000 without it; beats -1, -2, 3, 5 -> data 5.
REQ-038 en dropped for 3 cycles during WRITE -> no o_wr_en while en is low, exactly one write once en returns, and the correct data and address.
REQ-039 start pulsed during ACC and during DONE -> ignored, with the pass count and address sequence unchanged.
REQ-040 rst asserted after cell 3 is written -> outputs go to 0 immediately, no write for cell 4, and a new start restarts at addr 0.
REQ-041 NUM_TERM=1, WR_GAP=0, random i_valid gaps -> one write per accepted beat at consecutive addresses, with o_ready low only in WRITE and DONE.
